// File: rtl/mcs6530_pkg.sv
// Shared types and defaults for the RIOT scratch-RAM arbiter.
package mcs6530_pkg;

  localparam int unsigned RAM_AW = 6;
  localparam int unsigned RAM_DW = 8;

  // Who is owed the read data returning from the RAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_HOST
  } owner_t;

  // Host-side arbitration state.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_RET,
    DROP
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port scratch RAM between the 6502 bus and a host port.
// The CPU always wins; host accesses fill idle CPU cycles with a wait timeout.
module ram_arbiter
  import mcs6530_pkg::*;
#(
  parameter int unsigned AW      = RAM_AW,
  parameter int unsigned DW      = RAM_DW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          phi2,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          cpu_we_n,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_oe,
  input  logic          hst_req,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_a,
  input  logic [DW-1:0] hst_di,
  output logic          hst_gnt,
  output logic          hst_rvalid,
  output logic [DW-1:0] hst_rdata,
  output logic          hst_err,
  output logic          ram_en,
  output logic          ram_we_n,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_inc;
  owner_t        rd_owner_q, rd_owner_d;
  logic [DW-1:0] cpu_do_q, cpu_do_d;
  logic [DW-1:0] hst_rdata_q, hst_rdata_d;
  logic          gnt;
  logic          err;

  // FSM state and wait counter
  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read-return tag and held read data
  always_ff @(posedge phi2) begin
    if (rst) begin
      rd_owner_q  <= OWN_NONE;
      cpu_do_q    <= '0;
      hst_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      cpu_do_q    <= cpu_do_d;
      hst_rdata_q <= hst_rdata_d;
    end
  end

  // Next-state: host wait / timeout / drop sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RD_RET: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (hst_req && cpu_en) begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end else if (gnt) begin
          state_d = hst_we ? IDLE : RD_RET;
        end
      end
      WAIT: begin
        if (!hst_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (err) begin
          state_d = DROP;
          cnt_d   = '0;
        end else if (cpu_en) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = hst_we ? IDLE : RD_RET;
          cnt_d   = '0;
        end
      end
      DROP: begin
        if (!hst_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant decision, RAM port mux, read-return steering.
  // Everything is forced to its reset value while rst is high so an
  // in-flight read cannot leak out during the reset cycle.
  always_comb begin
    cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    gnt        = !rst && !cpu_en && hst_req && (state_q != DROP);
    err        = !rst && cpu_en && hst_req && (state_q == WAIT) && (cnt_inc == TIMEOUT_C);
    ram_en     = 1'b0;
    ram_we_n   = 1'b1;
    ram_a      = '0;
    ram_di     = '0;
    rd_owner_d = OWN_NONE;
    if (!rst && cpu_en) begin
      ram_en   = 1'b1;
      ram_we_n = cpu_we_n;
      ram_a    = cpu_a;
      ram_di   = cpu_di;
      if (cpu_we_n) rd_owner_d = OWN_CPU;
    end else if (gnt) begin
      ram_en   = 1'b1;
      ram_we_n = !hst_we;
      ram_a    = hst_a;
      ram_di   = hst_di;
      if (!hst_we) rd_owner_d = OWN_HOST;
    end
    hst_gnt     = gnt;
    hst_err     = err;
    cpu_oe      = !rst && (rd_owner_q == OWN_CPU);
    hst_rvalid  = !rst && (rd_owner_q == OWN_HOST);
    cpu_do      = rst ? '0 : (cpu_oe ? ram_do : cpu_do_q);
    hst_rdata   = rst ? '0 : (hst_rvalid ? ram_do : hst_rdata_q);
    cpu_do_d    = cpu_do;
    hst_rdata_d = hst_rdata;
  end

endmodule
